pipo_load_ctrl: RTL and testbench

Serial-to-parallel load controller that sequences an N-bit PIPO register (the `d_ffN` D-flip-flop bank with enable). It accepts a bit stream on a valid/ready handshake, assembles the word MSB-first in an internal shift register, then pulses the register enable for exactly one cycle with the assembled word on its parallel input. It sits between a serial source and the PIPO register and is the only driver of that register's `D` and `EN`.

---
 rtl/pipo_ctrl_pkg.sv | 11 +
 rtl/d_ffN.sv | 24 ++
 rtl/sipo_shift.sv | 27 ++
 rtl/pipo_load_ctrl.sv | 114 +++++++++++
 tb/tb_pipo_load_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pipo_ctrl_pkg.sv
// Shared types for the serial-to-parallel PIPO load controller.
package pipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } pipo_state_t;

endpackage

// File: rtl/d_ffN.sv
// N-bit D flip-flop bank with load enable (the PIPO register being sequenced).
module d_ffN #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         EN,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  logic [N-1:0] q_q;

  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) begin
      q_q <= '0;
    end else if (EN) begin
      q_q <= D;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/sipo_shift.sv
// N-bit MSB-first serial-in shift register with synchronous clear and shift enable.
module sipo_shift #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic         clr_i,
  input  logic         shift_en_i,
  input  logic         ser_in_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] sr_q;

  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) begin
      sr_q <= '0;
    end else if (clr_i) begin
      sr_q <= '0;
    end else if (shift_en_i) begin
      sr_q <= {sr_q[N-2:0], ser_in_i};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/pipo_load_ctrl.sv
// Collects a serial word MSB-first over valid/ready, then issues a one-cycle
// PIPO load (EN) with the assembled word held stable on D.
module pipo_load_ctrl
  import pipo_ctrl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                 CLK,
  input  logic                 N_RESET,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ser_in,
  input  logic                 ser_valid,
  output logic                 ser_ready,
  output logic [N-1:0]         D,
  output logic                 EN,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] bit_cnt
);

  localparam int unsigned CW = $clog2(N);

  pipo_state_t   state_q;
  logic [CW-1:0] bit_cnt_q;
  logic [N-1:0]  d_q;
  logic          en_q;
  logic          done_q;
  logic          busy_q;
  logic          ready_q;

  logic [N-1:0]  sr_c;
  logic [N-1:0]  word_c;
  logic          clr_c;
  logic          accept_c;
  logic          last_c;

  // abort beats an accepted bit in the same cycle
  assign clr_c    = (state_q == IDLE) && start;
  assign accept_c = (state_q == SHIFT) && ser_valid && !abort;
  assign last_c   = (bit_cnt_q == CW'(N - 1));
  assign word_c   = {sr_c[N-2:0], ser_in};

  sipo_shift #(.N(N)) u_shift (
    .CLK        (CLK),
    .N_RESET    (N_RESET),
    .clr_i      (clr_c),
    .shift_en_i (accept_c),
    .ser_in_i   (ser_in),
    .q_o        (sr_c)
  );

  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      d_q       <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
          end else if (ser_valid) begin
            if (last_c) begin
              // D only changes here, so it is stable around the EN edge
              state_q   <= LOAD;
              bit_cnt_q <= '0;
              d_q       <= word_c;
              en_q      <= 1'b1;
              ready_q   <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        LOAD: begin
          state_q <= DONE;
          en_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ser_ready = ready_q;
  assign D         = d_q;
  assign EN        = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_pipo_load_ctrl.sv
// Directed bench: pipo_load_ctrl (N=8 and N=2) each driving a d_ffN PIPO register.
module tb_pipo_load_ctrl;

  logic CLK;
  logic N_RESET;

  logic       start, abort, ser_in, ser_valid;
  logic       ser_ready, EN, busy, done;
  logic [7:0] D, Q;
  logic [2:0] bit_cnt;

  logic       start2, abort2, ser_in2, ser_valid2;
  logic       ser_ready2, EN2, busy2, done2;
  logic [1:0] D2, Q2;
  logic [0:0] bit_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  pipo_load_ctrl #(.N(8)) dut (
    .CLK(CLK), .N_RESET(N_RESET), .start(start), .abort(abort),
    .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .D(D), .EN(EN), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  d_ffN #(.N(8)) u_pipo (
    .CLK(CLK), .N_RESET(N_RESET), .EN(EN), .D(D), .Q(Q)
  );

  pipo_load_ctrl #(.N(2)) dut2 (
    .CLK(CLK), .N_RESET(N_RESET), .start(start2), .abort(abort2),
    .ser_in(ser_in2), .ser_valid(ser_valid2), .ser_ready(ser_ready2),
    .D(D2), .EN(EN2), .busy(busy2), .done(done2), .bit_cnt(bit_cnt2)
  );

  d_ffN #(.N(2)) u_pipo2 (
    .CLK(CLK), .N_RESET(N_RESET), .EN(EN2), .D(D2), .Q(Q2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // inputs change and outputs are sampled at the falling edge
  task automatic cyc();
    @(negedge CLK);
  endtask

  // One full word on the N=8 instance; cycle 0 is the cycle start is driven.
  task automatic run_word(input logic [7:0] w, input bit stall, input bit hold_start,
                          input int exp_lat);
    int cyc_n;
    int k;
    start = 1'b1;
    cyc();
    cyc_n = 1;
    start = hold_start;
    check("start_bitcnt0", 32'(bit_cnt), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(ser_ready), 32'd1);
    k = 0;
    while (k < 8) begin
      if (stall) begin
        ser_valid = 1'b0;
        cyc();
        cyc_n++;
        check("stall_hold_cnt", 32'(bit_cnt), 32'(k));
        check("stall_no_en", 32'(EN), 32'd0);
      end
      ser_valid = 1'b1;
      ser_in    = w[7-k];
      cyc();
      cyc_n++;
      k++;
      check("bit_cnt", 32'(bit_cnt), 32'(k % 8));
      check("en_timing", 32'(EN), (k == 8) ? 32'd1 : 32'd0);
    end
    ser_valid = 1'b0;
    check("latency", 32'(cyc_n), 32'(exp_lat));
    check("load_D", 32'(D), 32'(w));
    check("load_ready", 32'(ser_ready), 32'd0);
    check("load_done_lo", 32'(done), 32'd0);
    cyc();
    check("done_en_lo", 32'(EN), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("pipo_Q", 32'(Q), 32'(w));
    cyc();
    check("idle_done_lo", 32'(done), 32'd0);
    check("idle_busy_lo", 32'(busy), 32'd0);
    check("idle_D_held", 32'(D), 32'(w));
  endtask

  initial begin
    N_RESET = 1'b1;
    start = 1'b0; abort = 1'b0; ser_in = 1'b0; ser_valid = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; ser_in2 = 1'b0; ser_valid2 = 1'b0;
    cyc();
    cyc();
    N_RESET = 1'b0;
    cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_D", 32'(D), 32'd0);
    check("rst_ready", 32'(ser_ready), 32'd0);

    // ser_valid in IDLE is ignored
    ser_valid = 1'b1; ser_in = 1'b1;
    cyc();
    check("idle_ignore_valid", 32'(busy), 32'd0);
    check("idle_ignore_cnt", 32'(bit_cnt), 32'd0);
    ser_valid = 1'b0;

    // basic load, then the same word with a stall before every bit
    run_word(8'b11001010, 1'b0, 1'b0, 9);
    run_word(8'b11001010, 1'b1, 1'b0, 17);

    // abort after 5 bits, 6th bit arriving with abort is dropped
    run_word(8'b01011100, 1'b0, 1'b0, 9);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ser_valid = 1'b1; ser_in = 1'b1;
      cyc();
    end
    check("pre_abort_cnt", 32'(bit_cnt), 32'd5);
    abort = 1'b1;
    cyc();
    abort = 1'b0; ser_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(ser_ready), 32'd0);
    check("abort_no_en", 32'(EN), 32'd0);
    check("abort_D_kept", 32'(D), 32'h5C);
    cyc();
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_Q_kept", 32'(Q), 32'h5C);
    run_word(8'b00110101, 1'b0, 1'b0, 9);

    // start held through SHIFT/LOAD/DONE: one EN, next word only from IDLE
    run_word(8'b10010110, 1'b0, 1'b1, 9);
    cyc();
    check("restart_from_idle", 32'(busy), 32'd1);
    check("restart_cnt0", 32'(bit_cnt), 32'd0);
    start = 1'b0; abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("restart_abort_idle", 32'(busy), 32'd0);

    // asynchronous reset mid-word after 3 bits
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1; ser_in = 1'b1;
      cyc();
    end
    ser_valid = 1'b0;
    check("pre_rst_cnt", 32'(bit_cnt), 32'd3);
    N_RESET = 1'b1;
    #1;
    check("mid_rst_outputs", {21'd0, ser_ready, EN, busy, done, bit_cnt, 3'd0},
          32'd0);
    check("mid_rst_D", 32'(D), 32'd0);
    check("mid_rst_Q", 32'(Q), 32'd0);
    #1;
    N_RESET = 1'b0;
    cyc();
    run_word(8'b11110000, 1'b0, 1'b0, 9);

    // N=2 boundary: bits 1,0
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    check("n2_cnt0", 32'(bit_cnt2), 32'd0);
    ser_valid2 = 1'b1; ser_in2 = 1'b1;
    cyc();
    check("n2_cnt1", 32'(bit_cnt2), 32'd1);
    check("n2_no_en", 32'(EN2), 32'd0);
    ser_in2 = 1'b0;
    cyc();
    ser_valid2 = 1'b0;
    check("n2_en", 32'(EN2), 32'd1);
    check("n2_D", 32'(D2), 32'd2);
    check("n2_cnt_wrap", 32'(bit_cnt2), 32'd0);
    cyc();
    check("n2_en_lo", 32'(EN2), 32'd0);
    check("n2_done", 32'(done2), 32'd1);
    check("n2_Q", 32'(Q2), 32'd2);
    cyc();
    check("n2_idle", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
